// File: rtl/control_unit_if.sv
// Decode bus between instruction fetch (master) and the LITE-16 control unit (slave).
// The seven strobes are registered datapath controls; codeop is the raw opcode field.
interface control_unit_if;
    logic [3:0] codeop;
    logic       ri;
    logic       cmp;
    logic       mem;
    logic       ld;
    logic       st;
    logic       jmp;
    logic       fn;

    modport master (
        output codeop,
        input  ri, cmp, mem, ld, st, jmp, fn
    );

    modport slave (
        input  codeop,
        output ri, cmp, mem, ld, st, jmp, fn
    );
endinterface

// File: rtl/control_unit.sv
// LITE-16 instruction decoder: 4-bit opcode in, seven registered control strobes out.
// One cycle of latency, one opcode accepted per cycle, no other internal state.
module control_unit (
    input  logic         clk,
    input  logic         rst_n,
    control_unit_if.slave bus
);

    typedef struct packed {
        logic ri;
        logic cmp;
        logic mem;
        logic ld;
        logic st;
        logic jmp;
        logic fn;
    } strobes_t;

    // Unknown or unlisted opcodes fall to the default, which is the NOP pattern.
    function automatic strobes_t decode(input logic [3:0] op);
        strobes_t s;
        s = '0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: s.fn = 1'b1;
            4'h8: begin
                s.fn = 1'b1;
                s.ri = 1'b1;
            end
            4'h9: begin
                s.fn  = 1'b1;
                s.cmp = 1'b1;
            end
            4'hA: begin
                s.fn  = 1'b1;
                s.cmp = 1'b1;
                s.ri  = 1'b1;
            end
            4'hB: begin
                s.mem = 1'b1;
                s.ld  = 1'b1;
            end
            4'hC: begin
                s.mem = 1'b1;
                s.st  = 1'b1;
            end
            4'hD: begin
                s.ld = 1'b1;
                s.ri = 1'b1;
            end
            4'hE: begin
                s.jmp = 1'b1;
                s.ri  = 1'b1;
            end
            4'hF:    s = '0;
            default: s = '0;
        endcase
        return s;
    endfunction

    strobes_t dec_p0;
    strobes_t ctl_p1;

    // Stage 0: combinational decode of the incoming opcode.
    always_comb begin
        dec_p0 = decode(bus.codeop);
    end

    // Stage 1: output flops; reset clears them without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_p1 <= '0;
        end else begin
            ctl_p1 <= dec_p0;
        end
    end

    assign bus.ri  = ctl_p1.ri;
    assign bus.cmp = ctl_p1.cmp;
    assign bus.mem = ctl_p1.mem;
    assign bus.ld  = ctl_p1.ld;
    assign bus.st  = ctl_p1.st;
    assign bus.jmp = ctl_p1.jmp;
    assign bus.fn  = ctl_p1.fn;

    a_ld_st_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ctl_p1.ld && ctl_p1.st));
    a_mem_dir: assert property (@(posedge clk) disable iff (!rst_n)
        ctl_p1.mem |-> (ctl_p1.ld ^ ctl_p1.st));
    a_jmp_alone: assert property (@(posedge clk) disable iff (!rst_n)
        ctl_p1.jmp |-> (!ctl_p1.fn && !ctl_p1.mem));
    a_cmp_fn: assert property (@(posedge clk) disable iff (!rst_n)
        ctl_p1.cmp |-> ctl_p1.fn);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected strobes are queued when an opcode is
// driven and compared one edge later; invariants are checked on every compared cycle.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Bit order {ri, cmp, mem, ld, st, jmp, fn}.
    logic [6:0] tbl [16];
    logic [6:0] sb_q [$];

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.ri, bus.cmp, bus.mem, bus.ld, bus.st, bus.jmp, bus.fn};
    endfunction

    function automatic logic [6:0] model(input logic [3:0] op);
        if ($isunknown(op)) return 7'b0;
        return tbl[op];
    endfunction

    task automatic compare(input string tag);
        logic [6:0] o;
        o = outs();
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 7'd1, 7'd0);
        end else begin
            chk(tag, o, sb_q.pop_front());
        end
        chk("inv_ld_st", {6'd0, bus.ld & bus.st}, 7'd0);
        chk("inv_mem", {6'd0, bus.mem & ~(bus.ld ^ bus.st)}, 7'd0);
        chk("inv_jmp", {6'd0, bus.jmp & (bus.fn | bus.mem)}, 7'd0);
    endtask

    // Drive on the falling edge, compare 1 time unit after the capturing rising edge.
    task automatic drive(input logic [3:0] op, input string tag);
        @(negedge clk);
        bus.codeop = op;
        sb_q.push_back(model(op));
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        logic [3:0] op;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) tbl[i] = 7'b0000001;
        tbl[8]  = 7'b1000001;
        tbl[9]  = 7'b0100001;
        tbl[10] = 7'b1100001;
        tbl[11] = 7'b0011000;
        tbl[12] = 7'b0010100;
        tbl[13] = 7'b1001000;
        tbl[14] = 7'b1000010;
        tbl[15] = 7'b0000000;

        rst_n = 1'b0;
        bus.codeop = 4'h8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", outs(), 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release", outs(), 7'b0);
        drive(4'h8, "first_addi");

        for (int i = 0; i < 16; i++) drive(4'(i), "sweep");

        drive(4'h0, "lat_pre");
        #2;
        bus.codeop = 4'hC;
        sb_q.push_back(model(4'hC));
        #1;
        chk("lat_hold", outs(), 7'b0000001);
        @(posedge clk);
        #1;
        compare("lat_after");

        drive(4'hB, "areset_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_drop", outs(), 7'b0);
        @(negedge clk);
        chk("areset_low", outs(), 7'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("areset_resume", outs(), 7'b0011000);
        drive(4'hD, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            if (i % 10 == 5) op = 4'bxxxx;
            else op = 4'($urandom_range(0, 15));
            drive(op, "random");
        end

        drive(4'bxxxx, "x_codeop");
        drive(4'hF, "nop_tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
